// File: rtl/input_ram_ctrl_pkg.sv
// Shared types and defaults for the input-sample RAM controller.
package input_ram_ctrl_pkg;

  localparam int ADDR_WIDTH_DEF = 10;
  localparam int NUM_INPUTS_DEF = 784;
  localparam int BYTE_W         = 8;
  localparam int BYTE_CNT_W     = $clog2(BYTE_W);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PRIME = 3'd2,
    ST_SCAN  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/input_byte_unpacker.sv
// Byte-to-bit serializer: accepts a byte on a valid/ready link and presents
// it LSB first as a bit/valid pair, one bit per bit_take.
module input_byte_unpacker
  import input_ram_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [BYTE_W-1:0] in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              bit_out,
  output logic              bit_vld,
  input  logic              bit_take
);

  logic [BYTE_W-1:0]     shreg_q, shreg_d;
  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;   // bits left after the current one
  logic                  vld_q, vld_d;

  // A new byte may land while the last bit of the previous one is consumed,
  // which keeps a held in_valid bubble-free.
  assign in_ready = en && (!vld_q || (bit_take && cnt_q == '0));
  assign bit_out  = shreg_q[0];
  assign bit_vld  = vld_q;

  // Next-state: shift on take, reload on accept, flush on clr.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    if (bit_take) begin
      shreg_d = shreg_q >> 1;
      if (cnt_q == '0) vld_d = 1'b0;
      else             cnt_d = cnt_q - 1'b1;
    end
    if (in_valid && in_ready) begin
      shreg_d = in_byte;
      cnt_d   = BYTE_CNT_W'(BYTE_W - 1);
      vld_d   = 1'b1;
    end
    if (clr) begin
      vld_d = 1'b0;
      cnt_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
    end
  end

endmodule

// File: rtl/input_ram_ctrl.sv
// Owner of the 1-bit input-sample RAM: sequences host byte loads into it and
// streams it out to the first neuron layer, hiding the RAM read latency.
module input_ram_ctrl
  import input_ram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_INPUTS = NUM_INPUTS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  start,
  input  logic                  abort,
  input  logic [BYTE_W-1:0]     in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_bit,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic                  ram_data,
  input  logic                  ram_q
);

  // One extra bit so a full-depth sample count does not wrap.
  localparam int            CW       = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] N_CNT    = CW'(NUM_INPUTS);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_INPUTS - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] wr_idx_q, wr_idx_d;
  logic [CW-1:0] rd_idx_q, rd_idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic unp_en, unp_clr, bit_out, bit_vld;
  logic fire;

  // Only accept a byte whose first bit still falls inside the sample, so a
  // loader holding in_valid high is not charged for a byte that is dropped.
  assign unp_en  = (state_q == ST_LOAD) && !abort && ((wr_idx_q + CW'(ram_we)) < N_CNT);
  assign unp_clr = (state_q != ST_LOAD) || abort;

  input_byte_unpacker u_unpacker (
    .clk      (clk),
    .rst      (rst),
    .clr      (unp_clr),
    .en       (unp_en),
    .in_byte  (in_byte),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bit_out  (bit_out),
    .bit_vld  (bit_vld),
    .bit_take (ram_we)
  );

  assign ram_we    = (state_q == ST_LOAD) && bit_vld && !abort;
  assign ram_data  = ram_we && bit_out;
  assign out_valid = (state_q == ST_SCAN);
  assign out_last  = out_valid && (rd_idx_q == LAST_IDX);
  assign out_bit   = ram_q;
  assign fire      = out_valid && out_ready;
  assign busy      = busy_q;
  assign done      = done_q;

  // RAM address: write pointer in LOAD, look-ahead read pointer in SCAN so
  // ram_q already holds the next bit when the current one is accepted.
  always_comb begin
    case (state_q)
      ST_LOAD: ram_addr = wr_idx_q[ADDR_WIDTH-1:0];
      ST_SCAN: ram_addr = rd_idx_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(fire);
      default: ram_addr = '0;
    endcase
  end

  // Sequencer next-state; abort overrides everything.
  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d  = ST_LOAD;
          wr_idx_d = '0;
        end else if (start) begin
          state_d = ST_PRIME;
        end
      end
      ST_LOAD: begin
        if (ram_we) begin
          wr_idx_d = wr_idx_q + 1'b1;
          if (wr_idx_d == N_CNT) state_d = ST_DONE;
        end
      end
      ST_PRIME: begin
        state_d  = ST_SCAN;
        rd_idx_d = '0;
      end
      ST_SCAN: begin
        if (fire) begin
          rd_idx_d = rd_idx_q + 1'b1;
          if (out_last) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // Sequencer state and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule
